// File: rtl/gaussian_combine_unit.sv
// Box-Muller output stage: multiplies each radius h1 with a cos/sin pair, rounds, saturates,
// and queues x0 then x1 in a credit-protected FIFO. Launch-to-x_valid latency is 3 cycles.
module gaussian_combine_unit #(
  parameter int H_W        = 16,
  parameter int G_W        = 16,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [H_W-1:0]   h1_in,
  input  logic             h1_valid,
  output logic             h1_ready,
  input  logic [G_W-1:0]   g0_in,
  input  logic [G_W-1:0]   g1_in,
  input  logic             g_valid,
  output logic             g_ready,
  output logic [OUT_W-1:0] x_out,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [7:0]       sat_count,
  output logic             busy
);

  localparam int H_FRAC = 11;
  localparam int G_FRAC = 14;
  localparam int O_FRAC = 10;
  localparam int PW     = H_W + G_W + 1;
  localparam int SHIFT  = H_FRAC + G_FRAC - O_FRAC;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [PW:0] RND    = $signed({{(PW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}});
  localparam logic signed [PW:0] SAT_HI = $signed({{(PW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [PW:0] SAT_LO = $signed({{(PW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic [CW+1:0]      CREDIT_MAX = (CW+2)'(FIFO_DEPTH);
  localparam logic [AW-1:0]      LAST_RD    = AW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0]      LAST_WR    = AW'(FIFO_DEPTH - 2);

  // Returns {saturated, value}: round half up at the output LSB, then clamp.
  function automatic logic [OUT_W:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] s;
    s = ($signed({p[PW-1], p}) + RND) >>> SHIFT;
    if (s > SAT_HI)
      round_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (s < SAT_LO)
      round_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      round_sat = {1'b0, s[OUT_W-1:0]};
  endfunction

  // Operand holding registers
  logic [H_W-1:0] h1_q;
  logic [G_W-1:0] g0_q, g1_q;
  logic           h1_held_q, h1_held_d;
  logic           g_held_q, g_held_d;

  // Multiply (M1) and round/saturate (M2) stages
  logic signed [PW-1:0] p0_q, p1_q, p0_d, p1_d;
  logic                 m1_vld_q;
  logic [OUT_W-1:0]     r0_q, r1_q, r0_d, r1_d;
  logic                 sat0_q, sat1_q, sat0_d, sat1_d;
  logic                 m2_vld_q;

  // Output FIFO
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       sat_cnt_q, sat_cnt_d;

  logic          launch, push, pop, h1_cap, g_cap;
  logic [CW+1:0] credit_need;
  logic [8:0]    sat_sum;

  always_comb begin
    push = m2_vld_q;
    pop  = (cnt_q != '0) && x_ready;

    // Reserve room for every pair already in the pipeline before launching another.
    credit_need = {2'b00, cnt_q}
                + {{CW{1'b0}}, m1_vld_q, 1'b0}
                + {{CW{1'b0}}, m2_vld_q, 1'b0}
                + (CW+2)'(2);
    launch = h1_held_q && g_held_q && (credit_need <= CREDIT_MAX);

    h1_ready  = !h1_held_q || launch;
    g_ready   = !g_held_q || launch;
    h1_cap    = h1_valid && h1_ready;
    g_cap     = g_valid && g_ready;
    h1_held_d = h1_cap || (h1_held_q && !launch);
    g_held_d  = g_cap || (g_held_q && !launch);

    p0_d = $signed({{(G_W+1){1'b0}}, h1_q}) * $signed({{(H_W+1){g0_q[G_W-1]}}, g0_q});
    p1_d = $signed({{(G_W+1){1'b0}}, h1_q}) * $signed({{(H_W+1){g1_q[G_W-1]}}, g1_q});
    {sat0_d, r0_d} = round_sat(p0_q);
    {sat1_d, r1_d} = round_sat(p1_q);

    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      cnt_d    = cnt_d + CW'(2);
      wr_ptr_d = (wr_ptr_q == LAST_WR) ? '0 : wr_ptr_q + AW'(2);
    end
    if (pop) begin
      cnt_d    = cnt_d - CW'(1);
      rd_ptr_d = (rd_ptr_q == LAST_RD) ? '0 : rd_ptr_q + AW'(1);
    end

    sat_sum   = {1'b0, sat_cnt_q} + 9'(sat0_q && push) + 9'(sat1_q && push);
    sat_cnt_d = sat_sum[8] ? 8'hFF : sat_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h1_held_q <= 1'b0;
      g_held_q  <= 1'b0;
      m1_vld_q  <= 1'b0;
      m2_vld_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      h1_held_q <= h1_held_d;
      g_held_q  <= g_held_d;
      m1_vld_q  <= launch;
      m2_vld_q  <= m1_vld_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Datapath registers carry no reset; their valid flags gate every use.
  always_ff @(posedge clk) begin
    if (h1_cap)
      h1_q <= h1_in;
    if (g_cap) begin
      g0_q <= g0_in;
      g1_q <= g1_in;
    end
    if (launch) begin
      p0_q <= p0_d;
      p1_q <= p1_d;
    end
    if (m1_vld_q) begin
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      sat0_q <= sat0_d;
      sat1_q <= sat1_d;
    end
    if (push) begin
      mem_q[wr_ptr_q]          <= r0_q;
      mem_q[wr_ptr_q + AW'(1)] <= r1_q;
    end
  end

  assign x_valid   = (cnt_q != '0);
  assign x_out     = x_valid ? mem_q[rd_ptr_q] : '0;
  assign sat_count = sat_cnt_q;
  assign busy      = h1_held_q || g_held_q || m1_vld_q || m2_vld_q || x_valid;

endmodule

// File: tb/tb_gaussian_combine_unit.sv
// Randomized and directed bench for gaussian_combine_unit against a queue-based pairing model.
module tb_gaussian_combine_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] h1_in = '0;
  logic        h1_valid = 1'b0;
  logic        h1_ready;
  logic [15:0] g0_in = '0;
  logic [15:0] g1_in = '0;
  logic        g_valid = 1'b0;
  logic        g_ready;
  logic [15:0] x_out;
  logic        x_valid;
  logic        x_ready = 1'b0;
  logic [7:0]  sat_count;
  logic        busy;

  gaussian_combine_unit dut (
    .clk(clk), .reset(reset),
    .h1_in(h1_in), .h1_valid(h1_valid), .h1_ready(h1_ready),
    .g0_in(g0_in), .g1_in(g1_in), .g_valid(g_valid), .g_ready(g_ready),
    .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready),
    .sat_count(sat_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: captured operands are paired strictly in arrival order; each pair yields x0 then x1.
  logic [15:0] mh_q[$];
  logic [31:0] mg_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          sat_model = 0;
  int          pops = 0;
  int          hcap = 0;
  int          gcap = 0;
  logic [15:0] mh, e;
  logic [31:0] mg;
  logic [16:0] s0, s1;

  function automatic logic [16:0] ref_sample(input logic [15:0] h, input logic [15:0] g);
    longint p, r;
    p = longint'(h) * longint'($signed(g));
    r = (p + 16384) >>> 15;
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, r[15:0]};
  endfunction

  function automatic int min255(input int a);
    return (a > 255) ? 255 : a;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      mh_q.delete();
      mg_q.delete();
      exp_q.delete();
      got_q.delete();
      sat_model = 0;
    end else begin
      if (x_valid && x_ready) begin
        pops++;
        got_q.push_back(x_out);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample actual=%0h expected=none", x_out);
        end else begin
          e = exp_q.pop_front();
          check("x_out_stream", x_out, e);
        end
      end
      if (!x_valid) check("x_out_zero_when_empty", x_out, 0);
      if (h1_valid && h1_ready) begin mh_q.push_back(h1_in); hcap++; end
      if (g_valid && g_ready) begin mg_q.push_back({g0_in, g1_in}); gcap++; end
      while (mh_q.size() > 0 && mg_q.size() > 0) begin
        mh = mh_q.pop_front();
        mg = mg_q.pop_front();
        s0 = ref_sample(mh, mg[31:16]);
        s1 = ref_sample(mh, mg[15:0]);
        exp_q.push_back(s0[15:0]);
        exp_q.push_back(s1[15:0]);
        sat_model += int'(s0[16]) + int'(s1[16]);
      end
    end
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = random
  int rmode = 0;
  always begin
    @(posedge clk);
    #1;
    x_ready = (rmode == 2) ? ($urandom_range(0, 3) != 0) : (rmode == 1);
  end

  logic [15:0] hv  [256];
  logic [15:0] g0v [256];
  logic [15:0] g1v [256];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_h(input logic [15:0] v);
    int n;
    logic rdy;
    h1_in = v;
    h1_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = h1_ready;
      step();
      if (rdy) break;
      n++;
      if (n > 4000) begin
        checks++; failures++;
        $display("FAIL h1_accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    h1_valid = 1'b0;
  endtask

  task automatic send_g(input logic [15:0] a, input logic [15:0] b);
    int n;
    logic rdy;
    g0_in = a;
    g1_in = b;
    g_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = g_ready;
      step();
      if (rdy) break;
      n++;
      if (n > 4000) begin
        checks++; failures++;
        $display("FAIL g_accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    g_valid = 1'b0;
  endtask

  task automatic h_stream(input int s, input int n, input int gap);
    for (int i = s; i < s + n; i++) begin
      send_h(hv[i]);
      if (gap > 0) repeat ($urandom_range(0, gap)) step();
    end
  endtask

  task automatic g_stream(input int s, input int n, input int gap);
    for (int i = s; i < s + n; i++) begin
      send_g(g0v[i], g1v[i]);
      if (gap > 0) repeat ($urandom_range(0, gap)) step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("idle_within_budget", n < 3000, 1);
    step();
  endtask

  function automatic logic [15:0] rnd_h();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rnd_g();
    case ($urandom_range(0, 6))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h4000;
      3:       return 16'hC000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int p0, h0, g0c;
  logic stale;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_x_valid", x_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_busy", busy, 0);
    check("rst_h1_ready", h1_ready, 1);
    check("rst_g_ready", g_ready, 1);
    step();

    // T1: unity gain, latency from launch
    rmode = 1;
    step();
    h1_in = 16'h0800; g0_in = 16'h4000; g1_in = 16'hC000;
    h1_valid = 1'b1; g_valid = 1'b1;
    step();
    h1_valid = 1'b0; g_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t1_not_yet_valid", x_valid, 0);
      step();
    end
    @(negedge clk);
    check("t1_valid_at_launch_plus3", x_valid, 1);
    check("t1_x0", x_out, 16'h0400);
    @(posedge clk);
    @(negedge clk);
    check("t1_x1_valid", x_valid, 1);
    check("t1_x1", x_out, 16'hFC00);
    wait_idle();

    // T2: saturation in both directions
    got_q.delete();
    hv[0] = 16'hFFFF; g0v[0] = 16'h7FFF; g1v[0] = 16'h8000;
    fork h_stream(0, 1, 0); g_stream(0, 1, 0); join
    wait_idle();
    check("t2_count", got_q.size(), 2);
    check("t2_x0", got_q[0], 16'h7FFF);
    check("t2_x1", got_q[1], 16'h8000);
    check("t2_sat_count", sat_count, 2);

    // T3: rounding half up
    got_q.delete();
    hv[0] = 16'h0001; g0v[0] = 16'h4000; g1v[0] = 16'hC000;
    fork h_stream(0, 1, 0); g_stream(0, 1, 0); join
    wait_idle();
    check("t3_x0", got_q[0], 16'h0001);
    check("t3_x1", got_q[1], 16'h0000);
    check("t3_sat_unchanged", sat_count, min255(sat_model));

    // T4: stalled consumer fills FIFO, then drains in order
    rmode = 0;
    step(); step();
    for (int i = 0; i < 6; i++) begin hv[i] = rnd_h(); g0v[i] = rnd_g(); g1v[i] = rnd_g(); end
    h0 = hcap; g0c = gcap; p0 = pops;
    fork
      begin fork h_stream(0, 6, 0); g_stream(0, 6, 0); join end
    join_none
    repeat (30) @(negedge clk);
    check("t4_h1_ready_low", h1_ready, 0);
    check("t4_g_ready_low", g_ready, 0);
    check("t4_x_valid", x_valid, 1);
    check("t4_h_captured", hcap - h0, 5);
    check("t4_g_captured", gcap - g0c, 5);
    step();
    rmode = 1;
    wait fork;
    wait_idle();
    check("t4_drained", pops - p0, 12);

    // T5: g arrives well before h1
    for (int i = 0; i < 2; i++) begin hv[i] = rnd_h(); g0v[i] = rnd_g(); g1v[i] = rnd_g(); end
    p0 = pops;
    fork
      g_stream(0, 2, 0);
      begin
        repeat (5) step();
        @(negedge clk);
        check("t5_g_ready_blocked", g_ready, 0);
        check("t5_no_launch", x_valid, 0);
        check("t5_busy", busy, 1);
        step();
        h_stream(0, 2, 0);
      end
    join
    wait_idle();
    check("t5_samples", pops - p0, 4);

    // T6: reset with buffered and in-flight data
    rmode = 0;
    step(); step();
    for (int i = 0; i < 4; i++) begin hv[i] = rnd_h(); g0v[i] = rnd_g(); g1v[i] = rnd_g(); end
    fork h_stream(0, 2, 0); g_stream(0, 2, 0); join
    repeat (6) step();
    rmode = 1;
    step();
    rmode = 0;
    step(); step();
    fork h_stream(2, 1, 0); g_stream(2, 1, 0); join
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t6_x_valid", x_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_sat_count", sat_count, 0);
    check("t6_h1_ready", h1_ready, 1);
    check("t6_g_ready", g_ready, 1);
    check("t6_x_out", x_out, 0);
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (x_valid) stale = 1'b1;
    end
    check("t6_no_stale", stale, 0);
    step();
    rmode = 1;
    p0 = pops;
    fork h_stream(3, 1, 0); g_stream(3, 1, 0); join
    wait_idle();
    check("t6_fresh_pair", pops - p0, 2);

    // Randomized traffic with random gaps and consumer stalls
    for (int i = 0; i < 60; i++) begin hv[i] = rnd_h(); g0v[i] = rnd_g(); g1v[i] = rnd_g(); end
    rmode = 2;
    p0 = pops;
    fork h_stream(0, 60, 3); g_stream(0, 60, 3); join
    rmode = 1;
    wait_idle();
    check("rand_samples", pops - p0, 120);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_sat_count", sat_count, min255(sat_model));

    // sat_count must stick at 255
    for (int i = 0; i < 130; i++) begin hv[i] = 16'hFFFF; g0v[i] = 16'h7FFF; g1v[i] = 16'h8000; end
    fork h_stream(0, 130, 0); g_stream(0, 130, 0); join
    wait_idle();
    check("sat_clamp_255", sat_count, 8'hFF);
    check("sat_clamp_model", sat_count, min255(sat_model));
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
